uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmitter among NUM_REQ requesters.
- Each requester sends a multi-byte packet, ended by req_last. The packet holds the transmitter until it completes, or until MAX_BURST bytes have been sent.
- Sequences the transmitter handshake (tx_en, tx_wr, tx_busy) one byte at a time and flags a transmitter that never goes busy.
- Sits between client logic and the UART top-level data/Tx_EN/Tx_WR/busy pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, cycles allowed after tx_wr for tx_busy to rise.
- MAX_BURST, 16, maximum bytes per grant before forced release.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request, level.
- req_data  input  8*NUM_REQ  byte from requester i, bits [8i+7:8i].
- req_last  input  NUM_REQ  byte currently presented is the last of the packet.
- grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- ack  output  NUM_REQ  one-cycle pulse: presented byte accepted; present the next byte.
- tx_data  output  8  byte to UART data input.
- tx_en  output  1  UART Tx_EN.
- tx_wr  output  1  UART Tx_WR, one-cycle write strobe.
- tx_busy  input  1  UART busy.
- err_clr  input  1  clears timeout_err.
- timeout_err  output  1  sticky: tx_busy did not rise within BUSY_TIMEOUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant=0, ack=0, tx_data=0, tx_en=0, tx_wr=0, timeout_err=0.
  - State=IDLE; round-robin pointer=0; timeout and burst counters=0.
  - Reset mid-byte drops tx_wr/tx_en immediately; no ack is issued.
- All outputs are registered.
- States: IDLE, WRITE, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE:
  - Transitions when any req=1 and tx_busy=0.
  - Winner = first set req scanning from pointer upward, with wrap-around.
  - Next edge: grant=onehot(winner), tx_data=req_data[winner], last_q=req_last[winner], tx_en=1, tx_wr=1, ack[winner]=1, burst=1, state=WRITE.
  - Latency: req sampled at edge N gives tx_wr high in cycle N+1.
- WRITE (one cycle): next edge tx_wr=0, ack=0, timeout counter=0, state=WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 without tx_busy: timeout_err=1, state=RELEASE.
- WAIT_DONE: on tx_busy=0:
  - If last_q=1, or req[owner]=0, or burst==MAX_BURST -> RELEASE.
  - Otherwise latch the next byte exactly as in IDLE (tx_data, last_q, tx_wr=1, ack pulse), burst+1, state=WRITE.
- RELEASE (one cycle): grant=0, tx_en=0, pointer=(owner+1) mod NUM_REQ, state=IDLE.
- tx_en is high in WRITE, WAIT_BUSY and WAIT_DONE.
- Requester obligations:
  - Hold req_data/req_last stable from req assertion until its ack.
  - The next byte must be valid before tx_busy falls.
- Owner drops req mid-byte: the current byte completes normally, then release. No abort.
- Non-owner req changes while granted: ignored until IDLE.
- timeout_err and err_clr:
  - err_clr=1 clears timeout_err.
  - Simultaneous set and err_clr in the same cycle: set wins.
- tx_busy=1 in IDLE: no grant until it falls.
- Pointer wrap: owner NUM_REQ-1 -> pointer 0.
- At most one ack bit and one grant bit are high in any cycle.

Test Plan:
- Single byte: req[2]=1, req_data[2]=8'hA5, req_last[2]=1; busy model rises 2 cycles after tx_wr and is high 10 cycles -> tx_wr and ack[2] pulse exactly once; tx_data=8'hA5; grant=4'b0100 until 1 cycle after busy falls; then grant=0 and pointer=3.
- Fairness: req=4'b1111 held, every byte has last=1 -> grant order 0,1,2,3,0; each owner gets one tx_wr.
- Burst: req[1] held with 3 bytes 8'h11, 8'h22, 8'h33 (last on the third); req[0] also asserted -> three consecutive writes for requester 1 with no intervening grant; requester 0 granted afterwards.
- MAX_BURST=4, requester never asserts last -> release after the 4th byte; another pending requester is granted next.
- Busy never rises -> timeout_err=1 exactly BUSY_TIMEOUT cycles after tx_wr; grant released; err_clr pulse clears it; err_clr coincident with a new timeout leaves it at 1.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously. After release, req[3] is granted first with pointer=0, provided req[0..2]=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ packet sources.
// Drives the Tx_EN / Tx_WR / busy handshake one byte at a time and flags a dead transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int MAX_BURST    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  output logic                 tx_wr,
  input  logic                 tx_busy,
  input  logic                 err_clr,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_wr_q, tx_wr_d;
  logic               err_q, err_d;

  logic               win_found_s;
  logic [IW-1:0]      win_idx_s;
  logic [IW-1:0]      cand_s;
  logic [IW-1:0]      sel_s;
  logic               load_s;
  logic               release_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin winner: scanning from high offset to low lets the lowest offset from ptr win.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_s      = {IW{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s      = IW'((int'(ptr_q) + i) % NUM_REQ);
      win_found_s = win_found_s | req[cand_s];
      win_idx_s   = req[cand_s] ? cand_s : win_idx_s;
    end
  end

  // Next-state and next-output logic for the transmit sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ack_d     = {NUM_REQ{1'b0}};
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    tx_wr_d   = 1'b0;
    err_d     = err_clr ? 1'b0 : err_q;
    load_s    = 1'b0;
    release_s = 1'b0;
    sel_s     = (state_q == IDLE) ? win_idx_s : owner_q;

    case (state_q)
      IDLE: begin
        load_s = win_found_s & ~tx_busy;
      end
      WRITE: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if ((cnt_q + CW'(1)) >= CW'(BUSY_TIMEOUT - 1)) begin
          cnt_d     = cnt_q + CW'(1);
          err_d     = 1'b1;
          release_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (last_q || !req[owner_q] || (burst_q >= BW'(MAX_BURST))) begin
          release_s = 1'b1;
        end else begin
          load_s = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Loading a byte is identical for a fresh grant and a burst continuation.
    if (load_s) begin
      state_d   = WRITE;
      owner_d   = sel_s;
      grant_d   = onehot(sel_s);
      ack_d     = onehot(sel_s);
      tx_data_d = req_data[{sel_s, 3'b000} +: 8];
      last_d    = req_last[sel_s];
      tx_en_d   = 1'b1;
      tx_wr_d   = 1'b1;
      burst_d   = (state_q == IDLE) ? BW'(1) : (burst_q + BW'(1));
    end else if (release_s) begin
      state_d = RELEASE;
      grant_d = {NUM_REQ{1'b0}};
      tx_en_d = 1'b0;
      ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : (owner_q + IW'(1));
    end else begin
      owner_d = owner_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= {IW{1'b0}};
      owner_q   <= {IW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      burst_q   <= {BW{1'b0}};
      last_q    <= 1'b0;
      grant_q   <= {NUM_REQ{1'b0}};
      ack_q     <= {NUM_REQ{1'b0}};
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_wr_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_wr_q   <= tx_wr_d;
      err_q     <= err_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_en       = tx_en_q;
  assign tx_wr       = tx_wr_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed bytes, a busy model
// answers each write, and every write is compared against the expected owner/byte order.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int MAX_BURST    = 4;
  localparam int BUSY_LEN     = 10;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_data;
  logic                 tx_en;
  logic                 tx_wr;
  logic                 tx_busy;
  logic                 err_clr;
  logic                 timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] rq [NUM_REQ][$];
  int         exp_own [$];
  logic [7:0] exp_dat [$];
  bit         busy_en = 1'b1;
  bit         prev_wr = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .grant      (grant),
    .ack        (ack),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_wr      (tx_wr),
    .tx_busy    (tx_busy),
    .err_clr    (err_clr),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic send(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_wr(input int r, input logic [7:0] d);
    exp_own.push_back(r);
    exp_dat.push_back(d);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!(exp_own.size() == 0 && grant == '0 && tx_busy == 1'b0 && req == '0) && k < 600);
    check_eq({tag, "_drained"}, exp_own.size(), 0);
    check_eq({tag, "_idle_grant"}, grant, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_wr(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (tx_wr !== 1'b1 && k < 50);
    check_eq({tag, "_wr_seen"}, tx_wr, 1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (tx_busy !== lvl && k < 50);
    check_eq({tag, "_busy_level"}, tx_busy, lvl);
  endtask

  // Transmitter model: busy rises two cycles after a write and stays high BUSY_LEN cycles.
  initial begin : busy_model
    int dly;
    int hold;
    dly = 0;
    hold = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_busy = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1'b1;
          hold = BUSY_LEN;
        end
      end else if (tx_wr === 1'b1 && busy_en) begin
        dly = 2;
      end
    end
  end

  // Requesters: present the head of each queue, advance on ack.
  initial begin : req_driver
    req      = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req[i]              = 1'b1;
          req_data[i*8 +: 8]  = rq[i][0][7:0];
          req_last[i]         = rq[i][0][8];
        end else begin
          req[i]      = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin : sb_monitor
    int o;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        check_eq("wr_single_cycle", prev_wr, 0);
        check_eq("wr_expected", exp_own.size() > 0, 1);
        if (exp_own.size() > 0) begin
          o = exp_own.pop_front();
          d = exp_dat.pop_front();
          check_eq("wr_grant", grant, oh(o));
          check_eq("wr_ack", ack, oh(o));
          check_eq("wr_data", tx_data, d);
          check_eq("wr_tx_en", tx_en, 1);
        end
      end
      prev_wr = tx_wr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    reset   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_tx_en", tx_en, 0);
    check_eq("rst_tx_wr", tx_wr, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Fairness: all four requesting, every byte last -> 0,1,2,3,0.
    send(0, 8'h10, 1'b1); send(0, 8'h14, 1'b1);
    send(1, 8'h21, 1'b1); send(2, 8'h32, 1'b1); send(3, 8'h43, 1'b1);
    expect_wr(0, 8'h10); expect_wr(1, 8'h21); expect_wr(2, 8'h32);
    expect_wr(3, 8'h43); expect_wr(0, 8'h14);
    wait_idle("fair");

    // Single byte from requester 2; grant held until one cycle after busy falls.
    send(2, 8'hA5, 1'b1);
    expect_wr(2, 8'hA5);
    wait_busy(1'b1, "t1_rise");
    check_eq("t1_tx_en_busy", tx_en, 1);
    wait_busy(1'b0, "t1_fall");
    check_eq("t1_grant_hold", grant, 4'b0100);
    @(negedge clk); #1;
    check_eq("t1_grant_rel", grant, 0);
    check_eq("t1_tx_en_rel", tx_en, 0);
    wait_idle("single");

    // Pointer now 3: requester 3 beats requester 0, then wrap to 0.
    send(0, 8'h0A, 1'b1); send(3, 8'h3A, 1'b1);
    expect_wr(3, 8'h3A); expect_wr(0, 8'h0A);
    wait_idle("ptr_wrap");

    // Burst: requester 1 keeps the transmitter for its 3-byte packet.
    send(1, 8'h11, 1'b0); send(1, 8'h22, 1'b0); send(1, 8'h33, 1'b1);
    send(0, 8'h01, 1'b1);
    expect_wr(1, 8'h11); expect_wr(1, 8'h22); expect_wr(1, 8'h33); expect_wr(0, 8'h01);
    wait_idle("burst");

    // MAX_BURST forced release after 4 bytes; requester 2 gets a turn in between.
    for (int i = 0; i < 6; i++) send(1, 8'hB0 + 8'(i), (i == 5) ? 1'b1 : 1'b0);
    send(2, 8'hC0, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr(1, 8'hB0 + 8'(i));
    expect_wr(2, 8'hC0);
    expect_wr(1, 8'hB4); expect_wr(1, 8'hB5);
    wait_idle("max_burst");

    // Busy never rises: timeout after BUSY_TIMEOUT cycles, release, clear.
    busy_en = 1'b0;
    send(3, 8'h7E, 1'b1);
    expect_wr(3, 8'h7E);
    wait_wr("to1");
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (timeout_err !== 1'b1 && k < 40);
    check_eq("to1_latency", k, BUSY_TIMEOUT);
    @(negedge clk); #1;
    check_eq("to1_grant_rel", grant, 0);
    check_eq("to1_sticky", timeout_err, 1);
    wait_idle("to1");
    err_clr = 1'b1;
    @(negedge clk); #1;
    err_clr = 1'b0;
    check_eq("to1_err_clr", timeout_err, 0);

    // Second timeout with err_clr landing on the setting edge: set wins.
    send(0, 8'h5A, 1'b1);
    expect_wr(0, 8'h5A);
    wait_wr("to2");
    repeat (BUSY_TIMEOUT - 1) @(negedge clk);
    #1;
    check_eq("to2_pre", timeout_err, 0);
    err_clr = 1'b1;
    @(negedge clk); #1;
    check_eq("to2_set_wins", timeout_err, 1);
    err_clr = 1'b0;
    @(negedge clk); #1;
    check_eq("to2_sticky", timeout_err, 1);
    wait_idle("to2");
    busy_en = 1'b1;

    // Asynchronous reset while in WAIT_DONE.
    send(1, 8'h5C, 1'b1);
    expect_wr(1, 8'h5C);
    wait_busy(1'b1, "rst_rise");
    @(negedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_grant", grant, 0);
    check_eq("rst_mid_ack", ack, 0);
    check_eq("rst_mid_tx_data", tx_data, 0);
    check_eq("rst_mid_tx_en", tx_en, 0);
    check_eq("rst_mid_tx_wr", tx_wr, 0);
    check_eq("rst_mid_timeout_err", timeout_err, 0);
    rq[1].delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;

    // After reset only requester 3 asks; no grant while busy is still high.
    send(3, 8'hC3, 1'b1);
    expect_wr(3, 8'hC3);
    repeat (2) @(negedge clk);
    #1;
    if (tx_busy === 1'b1) check_eq("busy_blocks_grant", grant, 0);
    wait_idle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
